// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences ecall/mret into a stall, a one-cycle PC redirect and a flush drain; owns mepc and the trap counter
module trap_ctrl #(
  parameter int          FLUSH_CYCLES = 3,
  parameter logic [31:0] RESET_MEPC   = 32'h0000_0000,
  parameter logic [2:0]  CSR_E        = 3'h4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_csr_cmd,
  input  logic        i_is_mret,
  input  logic [31:0] trap_vector,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mepc,
  output logic [15:0] trap_count
);
  typedef enum logic [1:0] {IDLE, WAIT_CSR, REDIRECT, DRAIN} state_t;
  state_t      r_state;
  logic        r_src_mepc;
  logic [3:0]  r_cnt;
  logic        r_stall;
  logic        r_flush;
  logic        r_redir;
  logic [31:0] r_mepc;
  logic [15:0] r_count;
  logic        w_ecall;
  logic        w_mret;
  assign w_ecall = i_valid && (i_csr_cmd == CSR_E);
  assign w_mret  = i_valid && i_is_mret;
  // Trap FSM; stall/flush/redirect_valid are registered alongside the next state so inputs never reach them combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_src_mepc <= 1'b0;
      r_cnt      <= 4'd0;
      r_stall    <= 1'b0;
      r_flush    <= 1'b0;
      r_redir    <= 1'b0;
      r_mepc     <= RESET_MEPC;
      r_count    <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ecall) begin
            r_mepc     <= i_pc;
            r_count    <= r_count + 16'd1;
            r_src_mepc <= 1'b0;
            r_state    <= WAIT_CSR;
            r_stall    <= 1'b1;
            r_flush    <= 1'b1;
          end else if (w_mret) begin
            r_src_mepc <= 1'b1;
            r_state    <= REDIRECT;
            r_stall    <= 1'b1;
            r_flush    <= 1'b1;
            r_redir    <= 1'b1;
          end
        end
        WAIT_CSR: begin
          r_state <= REDIRECT;
          r_redir <= 1'b1;
        end
        REDIRECT: begin
          r_cnt   <= 4'(FLUSH_CYCLES);
          r_state <= DRAIN;
          r_stall <= 1'b0;
          r_redir <= 1'b0;
        end
        DRAIN: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= IDLE;
            r_flush <= 1'b0;
          end
        end
      endcase
    end
  end
  assign stall          = r_stall;
  assign flush          = r_flush;
  assign redirect_valid = r_redir;
  assign redirect_pc    = r_redir ? ((r_src_mepc ? r_mepc : trap_vector) & 32'hFFFF_FFFC) : 32'h0;
  assign mepc           = r_mepc;
  assign trap_count     = r_count;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed checks of ecall/mret sequencing, reset abort and counter wrap
module tb_trap_ctrl;
  localparam logic [2:0] CSR_E = 3'h4;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [2:0]  i_csr_cmd;
  logic        i_is_mret;
  logic [31:0] trap_vector;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mepc;
  logic [15:0] trap_count;
  int          total = 0;
  int          bad = 0;
  int          fl, st, rd, idx;
  logic [31:0] rpc;
  trap_ctrl #(.FLUSH_CYCLES(3), .RESET_MEPC(32'h0), .CSR_E(CSR_E)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_pc(i_pc), .i_csr_cmd(i_csr_cmd),
    .i_is_mret(i_is_mret), .trap_vector(trap_vector), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mepc(mepc), .trap_count(trap_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Watches one busy period starting the cycle after the accept edge; stops on the first IDLE sample
  task automatic run(output int n_fl, output int n_st, output int n_rd, output int r_idx, output logic [31:0] r_pc);
    bit done = 0;
    n_fl = 0; n_st = 0; n_rd = 0; r_idx = 0; r_pc = 32'hDEAD_BEEF;
    for (int i = 1; i <= 20 && !done; i++) begin
      if (!flush) done = 1;
      else begin
        n_fl++;
        if (stall) n_st++;
        if (redirect_valid) begin
          n_rd++;
          r_idx = i;
          r_pc = redirect_pc;
        end
        tick();
      end
    end
    if (!done) chk("busy_timeout", 32'(flush), 32'd0);
  endtask
  initial begin
    reset = 1; i_valid = 0; i_pc = 0; i_csr_cmd = 0; i_is_mret = 0; trap_vector = 0;
    tick(); tick();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redir", 32'(redirect_valid), 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_mepc", mepc, 0);
    chk("rst_cnt", 32'(trap_count), 0);
    reset = 0;
    tick(); tick(); tick();
    chk("idle_flush", 32'(flush), 0);
    chk("idle_cnt", 32'(trap_count), 0);
    // ecall
    i_valid = 1; i_pc = 32'h100; i_csr_cmd = CSR_E; trap_vector = 32'h203;
    tick();
    i_valid = 0; i_csr_cmd = 0;
    chk("ec_mepc", mepc, 32'h100);
    chk("ec_cnt", 32'(trap_count), 1);
    chk("ec_redir_t1", 32'(redirect_valid), 0);
    run(fl, st, rd, idx, rpc);
    chk("ec_flush_len", fl, 5);
    chk("ec_stall_len", st, 2);
    chk("ec_redir_n", rd, 1);
    chk("ec_redir_at", idx, 2);
    chk("ec_rpc", rpc, 32'h200);
    // mret, presented in the first IDLE cycle
    i_valid = 1; i_is_mret = 1;
    tick();
    i_valid = 0; i_is_mret = 0;
    run(fl, st, rd, idx, rpc);
    chk("mr_flush_len", fl, 4);
    chk("mr_stall_len", st, 1);
    chk("mr_redir_n", rd, 1);
    chk("mr_redir_at", idx, 1);
    chk("mr_rpc", rpc, 32'h100);
    chk("mr_cnt", 32'(trap_count), 1);
    chk("mr_mepc", mepc, 32'h100);
    // ecall and mret together: ecall wins
    i_valid = 1; i_pc = 32'h300; i_csr_cmd = CSR_E; i_is_mret = 1; trap_vector = 32'h405;
    tick();
    i_valid = 0; i_csr_cmd = 0; i_is_mret = 0;
    run(fl, st, rd, idx, rpc);
    chk("both_redir_at", idx, 2);
    chk("both_rpc", rpc, 32'h404);
    chk("both_mepc", mepc, 32'h300);
    chk("both_cnt", 32'(trap_count), 2);
    // reset asserted asynchronously in WAIT_CSR
    i_valid = 1; i_pc = 32'h500; i_csr_cmd = CSR_E; trap_vector = 32'h600;
    tick();
    i_valid = 0; i_csr_cmd = 0;
    chk("mid_in_wait", 32'(stall), 1);
    #2 reset = 1;
    #1;
    chk("mid_async_flush", 32'(flush), 0);
    chk("mid_mepc", mepc, 0);
    chk("mid_cnt", 32'(trap_count), 0);
    tick();
    reset = 0;
    rd = 0;
    for (int i = 0; i < 6; i++) begin
      if (redirect_valid || flush) rd++;
      tick();
    end
    chk("mid_no_redir", rd, 0);
    i_valid = 1; i_pc = 32'h600; i_csr_cmd = CSR_E; trap_vector = 32'h700;
    tick();
    i_valid = 0; i_csr_cmd = 0;
    run(fl, st, rd, idx, rpc);
    chk("post_rst_at", idx, 2);
    chk("post_rst_rpc", rpc, 32'h700);
    chk("post_rst_mepc", mepc, 32'h600);
    chk("post_rst_cnt", 32'(trap_count), 1);
    // counter wrap with ecalls offered every cycle
    force dut.r_count = 16'hFFFE;
    #1 release dut.r_count;
    chk("wrap_preload", 32'(trap_count), 32'hFFFE);
    i_valid = 1; i_pc = 32'h800; i_csr_cmd = CSR_E; trap_vector = 32'h900;
    tick();
    chk("wrap_ffff", 32'(trap_count), 32'hFFFF);
    i_pc = 32'h840;
    run(fl, st, rd, idx, rpc);
    chk("wrap_busy_ign_cnt", 32'(trap_count), 32'hFFFF);
    chk("wrap_busy_ign_mepc", mepc, 32'h800);
    chk("wrap_flush_len", fl, 5);
    tick();
    chk("wrap_no_gap", 32'(stall), 1);
    chk("wrap_zero", 32'(trap_count), 0);
    chk("wrap_mepc2", mepc, 32'h840);
    i_valid = 0; i_csr_cmd = 0;
    run(fl, st, rd, idx, rpc);
    chk("wrap_rpc", rpc, 32'h900);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
